// File: rtl/calc_nport_pkg.sv
// Shared encodings for calc_nport: field widths, command/response codes and
// the per-port capture FSM state encodings.
package calc_nport_pkg;

    localparam int CMD_W  = 4;
    localparam int RESP_W = 2;

    typedef logic [CMD_W-1:0]  cmd_t;
    typedef logic [RESP_W-1:0] resp_t;

    localparam cmd_t CMD_NOP = 4'd0;
    localparam cmd_t CMD_ADD = 4'd1;
    localparam cmd_t CMD_SUB = 4'd2;
    localparam cmd_t CMD_SHL = 4'd5;
    localparam cmd_t CMD_SHR = 4'd6;

    localparam resp_t RESP_NONE = 2'd0;
    localparam resp_t RESP_OK   = 2'd1;
    localparam resp_t RESP_ERR  = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OPND2 = 2'd1;
    localparam logic [1:0] ST_ARB   = 2'd2;

endpackage

// File: rtl/calc_nport_port.sv
// One request port: captures command + operand1, then operand2 on the next
// cycle, and waits in ARB until the shared ALU grants it.
module calc_nport_port
    import calc_nport_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  cmd_t              cmd_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              grant_i,
    output logic [1:0]        state_o,
    output cmd_t              cmd_o,
    output logic [DATA_W-1:0] opa_o,
    output logic [DATA_W-1:0] opb_o
);

    logic [1:0]        state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;

    // Commands seen outside IDLE are dropped; the operand2 cycle ignores cmd_i.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_i != CMD_NOP) begin
                    cmd_d   = cmd_i;
                    opa_d   = data_i;
                    state_d = ST_OPND2;
                end
            end
            ST_OPND2: begin
                opb_d   = data_i;
                state_d = ST_ARB;
            end
            ST_ARB: begin
                if (grant_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    assign state_o = state_q;
    assign cmd_o   = cmd_q;
    assign opa_o   = opa_q;
    assign opb_o   = opb_q;

endmodule

// File: rtl/calc_nport.sv
// N-port calculator: per-port capture FSMs share one round-robin arbitrated ALU.
// Define CALC_NPORT_SHIFT_EN to build the shifter for commands 5/6.
module calc_nport
    import calc_nport_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
) (
    input  logic                          c_clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*CMD_W-1:0]    req_cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
    output logic [NUM_PORTS*RESP_W-1:0]   out_resp,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
`ifdef CALC_NPORT_SHIFT_EN
    localparam int SHW = $clog2(DATA_W);
`endif

    logic [1:0]        port_state [NUM_PORTS];
    cmd_t              port_cmd   [NUM_PORTS];
    logic [DATA_W-1:0] port_opa   [NUM_PORTS];
    logic [DATA_W-1:0] port_opb   [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] gnt_vec;

    logic             gnt_found;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    cmd_t              sel_cmd;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [DATA_W:0]   sum_w;
    resp_t             alu_resp;
    logic [DATA_W-1:0] alu_data;

    logic [NUM_PORTS-1:0][RESP_W-1:0] resp_q, resp_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_q, data_d;

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_PORTS) begin
            s = s - NUM_PORTS;
        end
        return s[PTR_W-1:0];
    endfunction

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        calc_nport_port #(
            .DATA_W (DATA_W)
        ) u_port (
            .clk_i   (c_clk),
            .rst_i   (reset),
            .cmd_i   (req_cmd_in[p*CMD_W +: CMD_W]),
            .data_i  (req_data_in[p*DATA_W +: DATA_W]),
            .grant_i (gnt_vec[p]),
            .state_o (port_state[p]),
            .cmd_o   (port_cmd[p]),
            .opa_o   (port_opa[p]),
            .opb_o   (port_opb[p])
        );

        assign req_vec[p] = (port_state[p] == ST_ARB);
        assign gnt_vec[p] = gnt_found && (gnt_idx == PTR_W'(p));
    end

    // Scan from the highest offset down so the request closest to ptr_q wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_vec[rr_idx(ptr_q, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_idx(ptr_q, i);
            end
        end
    end

    assign ptr_d = gnt_found ? rr_idx(gnt_idx, 1) : ptr_q;

    assign sel_cmd = port_cmd[gnt_idx];
    assign sel_a   = port_opa[gnt_idx];
    assign sel_b   = port_opb[gnt_idx];
    assign sum_w   = {1'b0, sel_a} + {1'b0, sel_b};

    // Anything not explicitly handled reports error with zero data.
    always_comb begin
        alu_resp = RESP_ERR;
        alu_data = '0;
        case (sel_cmd)
            CMD_ADD: begin
                if (!sum_w[DATA_W]) begin
                    alu_resp = RESP_OK;
                    alu_data = sum_w[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (sel_b <= sel_a) begin
                    alu_resp = RESP_OK;
                    alu_data = sel_a - sel_b;
                end
            end
`ifdef CALC_NPORT_SHIFT_EN
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = sel_a << sel_b[SHW-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = sel_a >> sel_b[SHW-1:0];
            end
`endif
            default: begin
                alu_resp = RESP_ERR;
                alu_data = '0;
            end
        endcase
    end

    always_comb begin
        resp_d = '0;
        data_d = '0;
        if (gnt_found) begin
            resp_d[gnt_idx] = alu_resp;
            data_d[gnt_idx] = alu_data;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            resp_q <= '0;
            data_q <= '0;
            ptr_q  <= '0;
        end else begin
            resp_q <= resp_d;
            data_q <= data_d;
            ptr_q  <= ptr_d;
        end
    end

    assign out_resp = resp_q;
    assign out_data = data_q;

endmodule

// File: tb/tb_calc_nport.sv
// Bench for calc_nport (4 ports, 32-bit): vector table, contention/reset
// sequences and random traffic, checked every cycle against expected queues.
module tb_calc_nport;

    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int EXP_W = 66;

    logic             c_clk;
    logic             reset;
    logic [NP*4-1:0]  req_cmd_in;
    logic [NP*DW-1:0] req_data_in;
    logic [NP*2-1:0]  out_resp;
    logic [NP*DW-1:0] out_data;

    int   cyc;
    int   total;
    int   bad;
    logic mon_en;

    // {cycle[65:34], resp[33:32], data[31:0]}
    logic [EXP_W-1:0] exp_q[NP][$];

    typedef struct {
        int          port;
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[14];

    calc_nport #(
        .NUM_PORTS (NP),
        .DATA_W    (DW)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [3:0] cmd, input logic [31:0] data);
        req_cmd_in[p*4 +: 4]    = cmd;
        req_data_in[p*DW +: DW] = data;
    endtask

    task automatic clear_all();
        req_cmd_in  = '0;
        req_data_in = '0;
    endtask

    task automatic check(input string name, input int p, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s port %0d cycle %0d: got %h want %h", name, p, cyc, act, exp);
        end
    endtask

    task automatic expect_resp(input int p, input int at, input logic [1:0] resp, input logic [31:0] data);
        exp_q[p].push_back({32'(at), resp, data});
    endtask

    function automatic logic [33:0] model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (cmd)
            4'd1: return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            4'd2: return (b > a) ? {2'd2, 32'd0} : {2'd1, 32'(a - b)};
`ifdef CALC_NPORT_SHIFT_EN
            4'd5: return {2'd1, 32'(a << b[4:0])};
            4'd6: return {2'd1, 32'(a >> b[4:0])};
`endif
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    // Uncontested op on one port: cmd+operand1 now, operand2 next cycle.
    task automatic issue(input int p, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] resp, input logic [31:0] data);
        set_port(p, cmd, a);
        expect_resp(p, cyc + 3, resp, data);
        step();
        set_port(p, 4'd0, b);
        step();
        set_port(p, 4'd0, 32'd0);
    endtask

    task automatic check_cycle();
        logic [1:0]       r;
        logic [31:0]      d;
        logic [EXP_W-1:0] e;
        for (int p = 0; p < NP; p++) begin
            r = out_resp[p*2 +: 2];
            d = out_data[p*DW +: DW];
            while (exp_q[p].size() > 0 && int'(exp_q[p][0][65:34]) < cyc) begin
                e = exp_q[p].pop_front();
                total++;
                bad++;
                $display("FAIL missed port %0d: response due at cycle %0d never matched, want resp %0d data %h",
                         p, int'(e[65:34]), e[33:32], e[31:0]);
            end
            if (exp_q[p].size() > 0 && int'(exp_q[p][0][65:34]) == cyc) begin
                e = exp_q[p].pop_front();
                check("resp", p, 64'(r), 64'(e[33:32]));
                check("data", p, 64'(d), 64'(e[31:0]));
            end else begin
                check("idle_resp", p, 64'(r), 64'd0);
                check("idle_data", p, 64'(d), 64'd0);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge c_clk);
            #2;
            if (mon_en) check_cycle();
        end
    end

    initial begin
        logic [3:0]  rcmd;
        logic [31:0] ra, rb;
        logic [33:0] m;
        logic [3:0]  cmd_pool [5];

        cyc = 0; total = 0; bad = 0; mon_en = 1'b0;
        reset = 1'b1;
        clear_all();

        vecs[0]  = '{0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000};
        vecs[1]  = '{0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0};
        vecs[2]  = '{0, 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0};
        vecs[3]  = '{1, 4'd2, 32'h0000_0010, 32'h0000_0010, 2'd1, 32'h0};
        vecs[4]  = '{3, 4'd2, 32'h0000_0100, 32'h0000_0001, 2'd1, 32'h0000_00FF};
        vecs[5]  = '{2, 4'd3, 32'h0000_0005, 32'h0000_0006, 2'd2, 32'h0};
        vecs[6]  = '{2, 4'd4, 32'h0000_0005, 32'h0000_0006, 2'd2, 32'h0};
        vecs[7]  = '{2, 4'd15, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0};
        vecs[8]  = '{1, 4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF};
        vecs[9]  = '{0, 4'd1, 32'h8000_0000, 32'h8000_0000, 2'd2, 32'h0};
`ifdef CALC_NPORT_SHIFT_EN
        vecs[10] = '{0, 4'd5, 32'h0000_0001, 32'h0000_0004, 2'd1, 32'h0000_0010};
        vecs[11] = '{1, 4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001};
        vecs[12] = '{3, 4'd5, 32'h0000_000F, 32'h0000_0024, 2'd1, 32'h0000_00F0};
        vecs[13] = '{2, 4'd6, 32'hF000_0000, 32'h0000_0008, 2'd1, 32'h00F0_0000};
`else
        vecs[10] = '{0, 4'd5, 32'h0000_0001, 32'h0000_0004, 2'd2, 32'h0};
        vecs[11] = '{1, 4'd6, 32'h8000_0000, 32'h0000_001F, 2'd2, 32'h0};
        vecs[12] = '{3, 4'd5, 32'h0000_000F, 32'h0000_0024, 2'd2, 32'h0};
        vecs[13] = '{2, 4'd6, 32'hF000_0000, 32'h0000_0008, 2'd2, 32'h0};
`endif

        // Reset state
        repeat (3) step();
        for (int p = 0; p < NP; p++) begin
            check("reset_resp", p, 64'(out_resp[p*2 +: 2]), 64'd0);
            check("reset_data", p, 64'(out_data[p*DW +: DW]), 64'd0);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        step();

        // All ports at once, twice: grants go 0,1,2,3 both times
        for (int rep = 0; rep < 2; rep++) begin
            for (int p = 0; p < NP; p++) begin
                set_port(p, 4'd1, 32'(p + 1));
                expect_resp(p, cyc + 3 + p, 2'd1, 32'(p + 2));
            end
            step();
            for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'd1);
            step();
            clear_all();
            repeat (6) step();
        end

        // Pointer moves past port 1, so port 2 beats port 0 next
        issue(1, 4'd1, 32'd5, 32'd6, 2'd1, 32'd11);
        repeat (3) step();
        set_port(0, 4'd1, 32'd100);
        set_port(2, 4'd1, 32'd200);
        expect_resp(2, cyc + 3, 2'd1, 32'd201);
        expect_resp(0, cyc + 4, 2'd1, 32'd102);
        step();
        set_port(0, 4'd0, 32'd2);
        set_port(2, 4'd0, 32'd1);
        step();
        clear_all();
        repeat (5) step();

        // Commands during OPND2 and ARB are ignored
        set_port(2, 4'd3, 32'd7);
        expect_resp(2, cyc + 3, 2'd2, 32'd0);
        step();
        set_port(2, 4'd1, 32'd9);
        step();
        set_port(2, 4'd1, 32'd4);
        step();
        clear_all();
        repeat (5) step();

        // Reset mid-operation discards the request; reset-cycle commands ignored
        set_port(0, 4'd1, 32'd2);
        step();
        set_port(0, 4'd0, 32'd3);
        set_port(1, 4'd1, 32'd5);
        reset = 1'b1;
        step();
        set_port(1, 4'd2, 32'd5);
        step();
        reset = 1'b0;
        clear_all();
        repeat (6) step();
        issue(0, 4'd1, 32'h10, 32'h20, 2'd1, 32'h30);
        step();

        // Vector table, back-to-back at the minimum 3-cycle spacing
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].port, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].resp, vecs[i].data);
            step();
        end
        repeat (4) step();

        // Random uncontested traffic
        cmd_pool[0] = 4'd1; cmd_pool[1] = 4'd2; cmd_pool[2] = 4'd5;
        cmd_pool[3] = 4'd6; cmd_pool[4] = 4'd7;
        for (int i = 0; i < 16; i++) begin
            rcmd = cmd_pool[$urandom_range(0, 4)];
            ra   = $urandom;
            rb   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
            m    = model(rcmd, ra, rb);
            issue($urandom_range(0, NP - 1), rcmd, ra, rb, m[33:32], m[31:0]);
            step();
        end

        repeat (6) step();
        for (int p = 0; p < NP; p++) begin
            check("drain", p, 64'(exp_q[p].size()), 64'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
